alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle controller that computes an 8-bit product (low byte, mod 256) by sequencing the shared 8-bit ALU through shift-and-add steps. It issues one ALU operation per cycle: ORR for the zero test, ADD, SLL and SRL. It registers each ALU result into its own working registers. It sits beside the core datapath and takes the ALU operand/opcode mux (via `AluOwn`) only while a multiply is in flight.

## Interface
- `WIDTH`, 8, datapath width; must equal ALU width (only 8 supported)
- `Clk`  in  1  clock, all state updates on rising edge
- `Reset`  in  1  synchronous, active-high; returns block to IDLE
- `Start`  in  1  request; sampled only in IDLE
- `Abort`  in  1  cancel in-flight multiply; sampled in TEST/ADD/SHL/SHR
- `Multiplicand`  in  8  operand A, latched on accepted Start
- `Multiplier`  in  8  operand B, latched on accepted Start
- `Busy`  out  1  high in TEST/ADD/SHL/SHR/DONE
- `Done`  out  1  one-cycle pulse in DONE
- `Product`  out  8  result register; holds last completed product
- `AluOwn`  out  1  high in TEST/ADD/SHL/SHR; datapath selects the sequencer's ALU drive
- `AluInputA`, `AluInputB`  out  8  ALU operands
- `AluOP`  out  2  ALU OP field
- `AluFunction`  out  2  ALU Function field
- `AluImmediate`  out  3  always 0
- `AluRD`  out  8  always 0
- `AluOut`  in  8  ALU result (combinational, same cycle)
- `AluZero`  in  1  ALU zero flag (AluOut == 0)

## Operation
- Working registers: `Mc` (multiplicand), `Mp` (multiplier), `Acc`. All are 8-bit; all arithmetic wraps mod 256.
- IDLE: `AluOwn`=0 and all Alu* outputs 0. If Start=1: Mc<=Multiplicand, Mp<=Multiplier, Acc<=0, then go to TEST.
- TEST: drive ORR (OP=10, Func=00), A=Mp, B=0.
  - If AluZero=1, go to DONE.
  - Otherwise, if Mp[0]=1, go to ADD; else go to SHL.
- ADD: drive ADD (OP=00, Func=00), A=Acc, B=Mc. Acc<=AluOut, then go to SHL.
- SHL: drive SLL (OP=11, Func=00), A=Mc, B=1. Mc<=AluOut, then go to SHR.
- SHR: drive SRL (OP=11, Func=01), A=Mp, B=1. Mp<=AluOut, then go to TEST.
- DONE: Product<=Acc on entry. Done=1 and AluOwn=0 in this state; next state is IDLE.
- Abort=1 in TEST/ADD/SHL/SHR: go to IDLE on the next edge, with no Done pulse and Product unchanged. The register update for that cycle's ALU op is discarded.
- Abort is ignored in IDLE and DONE.
- Start is ignored outside IDLE. It is not queued.
- Early termination: the loop ends as soon as Mp becomes 0, so high zero bits of B cost nothing.
- Reset values: state=IDLE, Mc=Mp=Acc=0, Product=0, Busy=0, Done=0, AluOwn=0, all Alu* outputs 0.

## Timing
- Start accepted at edge t0. TEST is first active at t0+1.
- Let n = index of B's highest set bit + 1 (n=0 for B=0), and p = popcount(B).
- Active cycles (TEST/ADD/SHL/SHR) = 3n + p + 1.
- Done is high in the cycle after edge t0 + 3n + p + 2.
- Product is valid from that same cycle and holds until the next DONE.
- Examples:
  - B=0: Done after t0+2.
  - B=5: Done after t0+13.
  - B=255: Done after t0+34 (maximum latency).
- Back-to-back: Start may be asserted in the DONE cycle but is not sampled. The earliest accept is the first IDLE cycle, i.e. one cycle after Done.
- Alu* outputs are combinational from state and registers. AluOut/AluZero are consumed in the same cycle; no ALU pipelining.
- Reset has priority over Abort and Start, in any state, including mid-multiply and DONE.
- Busy falls in the IDLE cycle following DONE or Abort.

## Test plan
- Reset, then Start with A=3, B=5 -> Done pulse one cycle after t0+13, Product=15. AluOwn high for exactly 12 cycles; the ALU op sequence matches TEST/ADD/SHL/SHR ordering.
- A=17, B=0 -> Done after t0+2, Product=0. Exactly one TEST cycle (ORR, A=0).
- A=255, B=255 -> Done after t0+34, Product=1 (65025 mod 256). Busy continuous.
- A=20, B=13, with Abort pulsed in the 5th active cycle -> IDLE on the next edge. No Done, Product keeps its prior value. A following Start with A=20, B=13 gives Product=4 (260 mod 256).
- Start held high continuously with A=2, B=3 -> one multiply per 1 + 8 + 1 + 1 cycles. Product=6 each time. Start is never sampled while Busy.
- Reset asserted in the ADD state -> next cycle: Busy=0, Done=0, AluOwn=0, Product=0, all Alu* outputs 0.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared 8-bit ALU,
// one ALU operation per cycle, and keeps the low byte of the product.
module alu_mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Multiplicand,
    input  logic [WIDTH-1:0] Multiplier,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Product,
    output logic             AluOwn,
    output logic [WIDTH-1:0] AluInputA,
    output logic [WIDTH-1:0] AluInputB,
    output logic [1:0]       AluOP,
    output logic [1:0]       AluFunction,
    output logic [2:0]       AluImmediate,
    output logic [7:0]       AluRD,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluZero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TEST = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             active;

    assign active = (state_q == S_TEST) || (state_q == S_ADD) ||
                    (state_q == S_SHL)  || (state_q == S_SHR);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mc_d    = Multiplicand;
                    mp_d    = Multiplier;
                    acc_d   = '0;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                if (AluZero) begin
                    prod_d  = acc_q;
                    state_d = S_DONE;
                end else if (mp_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_ADD: begin
                acc_d   = AluOut;
                state_d = S_SHL;
            end
            S_SHL: begin
                mc_d    = AluOut;
                state_d = S_SHR;
            end
            S_SHR: begin
                mp_d    = AluOut;
                state_d = S_TEST;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort drops whatever this cycle's ALU op would have written back.
        if (Abort && active) begin
            state_d = S_IDLE;
            mc_d    = mc_q;
            mp_d    = mp_q;
            acc_d   = acc_q;
            prod_d  = prod_q;
        end
    end

    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        AluOwn       = 1'b0;
        AluInputA    = '0;
        AluInputB    = '0;
        AluOP        = 2'b00;
        AluFunction  = 2'b00;
        AluImmediate = 3'b000;
        AluRD        = 8'h00;
        case (state_q)
            S_TEST: begin
                Busy      = 1'b1;
                AluOwn    = 1'b1;
                AluOP     = 2'b10;
                AluInputA = mp_q;
            end
            S_ADD: begin
                Busy      = 1'b1;
                AluOwn    = 1'b1;
                AluInputA = acc_q;
                AluInputB = mc_q;
            end
            S_SHL: begin
                Busy      = 1'b1;
                AluOwn    = 1'b1;
                AluOP     = 2'b11;
                AluInputA = mc_q;
                AluInputB = WIDTH'(1);
            end
            S_SHR: begin
                Busy        = 1'b1;
                AluOwn      = 1'b1;
                AluOP       = 2'b11;
                AluFunction = 2'b01;
                AluInputA   = mp_q;
                AluInputB   = WIDTH'(1);
            end
            S_DONE: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    assign Product = prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a queue of expected per-cycle outputs is built
// from each accepted multiply and compared every cycle; directed runs pin latency.
module tb_alu_mul_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start, Abort;
    logic [7:0] Multiplicand, Multiplier;
    logic       Busy, Done, AluOwn;
    logic [7:0] Product, AluInputA, AluInputB, AluOut, AluRD;
    logic [1:0] AluOP, AluFunction;
    logic [2:0] AluImmediate;
    logic       AluZero;

    always #5 Clk = ~Clk;

    alu_mul_sequencer #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Busy(Busy), .Done(Done), .Product(Product), .AluOwn(AluOwn),
        .AluInputA(AluInputA), .AluInputB(AluInputB), .AluOP(AluOP),
        .AluFunction(AluFunction), .AluImmediate(AluImmediate), .AluRD(AluRD),
        .AluOut(AluOut), .AluZero(AluZero)
    );

    // Shared ALU as seen by the sequencer
    always_comb begin
        AluOut = 8'h00;
        case (AluOP)
            2'b00: AluOut = AluInputA + AluInputB;
            2'b10: AluOut = AluInputA | AluInputB;
            2'b11: AluOut = (AluFunction == 2'b00) ? (AluInputA << AluInputB)
                                                   : (AluInputA >> AluInputB);
            default: AluOut = 8'h00;
        endcase
    end
    assign AluZero = (AluOut == 8'h00);

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       own;
        logic [1:0] op;
        logic [1:0] fn;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] prod;
    } exp_t;

    exp_t       q[$];
    logic [7:0] prod_m = 8'h00;
    int         checks = 0, failures = 0;
    int         cyc = 0, acc_cyc = 0, done_cyc = 0, prev_done = 0;
    int         own_cnt = 0, done_cnt = 0;
    bit         armed = 1'b0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(logic own, logic [1:0] op, logic [1:0] fn,
                                logic [7:0] a, logic [7:0] b, logic [7:0] p);
        exp_t e;
        e = '0;
        e.busy = 1'b1; e.own = own; e.op = op; e.fn = fn; e.a = a; e.b = b; e.prod = p;
        return e;
    endfunction

    // Expected cycle list for one multiply: test bit, optional add, shift both, repeat.
    task automatic build(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] mc, mp, acc;
        exp_t       e;
        mc = a; mp = b; acc = 8'h00;
        forever begin
            q.push_back(mk(1'b1, 2'b10, 2'b00, mp, 8'h00, prod_m));
            if (mp == 8'h00) break;
            if (mp[0]) begin
                q.push_back(mk(1'b1, 2'b00, 2'b00, acc, mc, prod_m));
                acc = acc + mc;
            end
            q.push_back(mk(1'b1, 2'b11, 2'b00, mc, 8'h01, prod_m));
            mc = mc << 1;
            q.push_back(mk(1'b1, 2'b11, 2'b01, mp, 8'h01, prod_m));
            mp = mp >> 1;
        end
        e = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, acc);
        e.done = 1'b1;
        q.push_back(e);
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            q.delete();
            prod_m = 8'h00;
            armed  = 1'b1;
        end else if (q.size() > 0) begin
            if (q[0].own && Abort) q.delete();
            else begin
                if (q[0].done) prod_m = q[0].prod;
                void'(q.pop_front());
            end
        end else if (Start) begin
            build(Multiplicand, Multiplier);
            acc_cyc = cyc;
            own_cnt = 0;
        end
        cyc++;
    end

    always @(negedge Clk) begin
        exp_t e;
        if (armed) begin
            e = '0;
            e.prod = prod_m;
            if (q.size() > 0) e = q[0];
            chk("cycle", 40'({Busy, Done, AluOwn, AluOP, AluFunction, AluInputA, AluInputB, Product}),
                40'(e));
            chk("alu_const", 40'({AluImmediate, AluRD}), 40'd0);
            if (AluOwn) own_cnt++;
            if (Done) begin
                prev_done = done_cyc;
                done_cyc  = cyc;
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && Busy; i++) tick();
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            #1;
            if (done_cnt > d0) break;
        end
        chk("done_seen", 40'(done_cnt > d0), 40'd1);
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int lat,
                           input logic [7:0] p, input int own);
        int d0;
        wait_idle();
        d0 = done_cnt;
        Start = 1'b1; Multiplicand = a; Multiplier = b;
        tick();
        Start = 1'b0;
        wait_done(d0);
        chk("latency", 40'(done_cyc - acc_cyc), 40'(lat));
        chk("product", 40'(Product), 40'(p));
        chk("own_cycles", 40'(own_cnt), 40'(own));
    endtask

    initial begin
        int d0;
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
        Multiplicand = 8'h00; Multiplier = 8'h00;
        tick(); tick();
        chk("reset_outputs", 40'({Busy, Done, AluOwn, AluOP, AluFunction, AluInputA,
                                  AluInputB, AluImmediate, AluRD, Product}), 40'd0);
        Reset = 1'b0;
        tick();

        run_mul(8'd3,   8'd5,   13, 8'd15, 12);
        run_mul(8'd17,  8'd0,   2,  8'd0,  1);
        run_mul(8'd255, 8'd255, 34, 8'd1,  33);
        run_mul(8'd3,   8'd5,   13, 8'd15, 12);

        // Abort in the 5th active cycle
        wait_idle();
        d0 = done_cnt;
        Start = 1'b1; Multiplicand = 8'd20; Multiplier = 8'd13;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort_idle", 40'({Busy, AluOwn}), 40'd0);
        chk("abort_product", 40'(Product), 40'd15);
        chk("abort_no_done", 40'(done_cnt), 40'(d0));
        run_mul(8'd20, 8'd13, 17, 8'd4, 16);

        // Start held high: back-to-back multiplies every 11 cycles
        wait_idle();
        Start = 1'b1; Multiplicand = 8'd2; Multiplier = 8'd3;
        d0 = done_cnt;
        wait_done(d0);
        for (int k = 0; k < 2; k++) begin
            wait_done(done_cnt);
            chk("b2b_period", 40'(done_cyc - prev_done), 40'd11);
            chk("b2b_product", 40'(Product), 40'd6);
        end
        Start = 1'b0;

        // Synchronous reset while in ADD
        wait_idle();
        Start = 1'b1; Multiplicand = 8'd3; Multiplier = 8'd5;
        tick();
        Start = 1'b0;
        tick();
        chk("in_add", 40'({AluOwn, AluOP, AluFunction}), 40'b1_00_00);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("reset_in_add", 40'({Busy, Done, AluOwn, AluOP, AluFunction, AluInputA,
                                 AluInputB, AluImmediate, AluRD, Product}), 40'd0);

        // Random traffic: Start/Abort/Reset noise against the cycle model
        for (int i = 0; i < 1500; i++) begin
            Start        = ($urandom_range(0, 2) == 0);
            Abort        = ($urandom_range(0, 19) == 0);
            Reset        = ($urandom_range(0, 299) == 0);
            Multiplicand = 8'($urandom);
            Multiplier   = 8'($urandom);
            tick();
        end
        Start = 1'b0; Abort = 1'b0; Reset = 1'b0;
        wait_idle();
        chk("final_idle", 40'(Busy), 40'd0);
        run_mul(8'd7, 8'd9, 3 * 4 + 2 + 2, 8'd63, 3 * 4 + 2 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
